// File: rtl/denormalize.sv
// denormalize: rebuilds (x, y, z) = length * (nx, ny, nz) in fixed point.
// Three shift-add multipliers share one bit-serial controller.
module denormalize #(
   parameter int WIDTH      = 32,
   parameter int FRAC_WIDTH = 30
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] length,
   input  logic [WIDTH-1:0] nx,
   input  logic [WIDTH-1:0] ny,
   input  logic [WIDTH-1:0] nz,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] z
);

   localparam int AW = 2 * WIDTH + 1;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [AW-1:0] RND  = AW'(1) << (FRAC_WIDTH - 1);
   localparam logic [AW-1:0] PMAX = (AW'(1) << (WIDTH - 1)) - AW'(1);
   localparam logic [AW-1:0] PMIN = ~PMAX;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [WIDTH-1:0] len_q;
   logic [WIDTH-1:0] nx_q, ny_q, nz_q;
   logic [AW-1:0]    ax_q, ay_q, az_q;
   logic [CW-1:0]    cnt_q;

   logic load, step, fin;

   function automatic logic [AW-1:0] mac(
      input logic [AW-1:0]    acc,
      input logic [WIDTH-1:0] n,
      input logic             en,
      input logic [CW-1:0]    sh
   );
      logic [AW-1:0] ext;
      ext = {{(AW - WIDTH){n[WIDTH-1]}}, n};
      return en ? acc + (ext << sh) : acc;
   endfunction

   function automatic logic [WIDTH-1:0] finish(input logic [AW-1:0] acc);
      logic signed [AW-1:0] r;
      r = $signed(acc + RND) >>> FRAC_WIDTH;
      if (r > $signed(PMAX))
         return PMAX[WIDTH-1:0];
      else if (r < $signed(PMIN))
         return PMIN[WIDTH-1:0];
      else
         return r[WIDTH-1:0];
   endfunction

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // next-state and datapath control
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step    = 1'b0;
      fin     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_d = MUL;
            end
         end
         MUL: begin
            step = 1'b1;
            if (cnt_q == LAST)
               state_d = FIN;
         end
         FIN: begin
            fin     = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q != IDLE);

   // operand latch, accumulation and result registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         len_q <= '0;
         nx_q  <= '0;
         ny_q  <= '0;
         nz_q  <= '0;
         ax_q  <= '0;
         ay_q  <= '0;
         az_q  <= '0;
         cnt_q <= '0;
         done  <= 1'b0;
         x     <= '0;
         y     <= '0;
         z     <= '0;
      end else begin
         done <= fin;
         if (load) begin
            len_q <= length;
            nx_q  <= nx;
            ny_q  <= ny;
            nz_q  <= nz;
            ax_q  <= '0;
            ay_q  <= '0;
            az_q  <= '0;
            cnt_q <= '0;
         end
         if (step) begin
            ax_q  <= mac(ax_q, nx_q, len_q[cnt_q], cnt_q);
            ay_q  <= mac(ay_q, ny_q, len_q[cnt_q], cnt_q);
            az_q  <= mac(az_q, nz_q, len_q[cnt_q], cnt_q);
            cnt_q <= cnt_q + CW'(1);
         end
         if (fin) begin
            x <= finish(ax_q);
            y <= finish(ay_q);
            z <= finish(az_q);
         end
      end
   end

endmodule

// File: tb/tb_denormalize.sv
// tb_denormalize: directed checks of scaling, rounding, saturation,
// latency, start-while-busy, back-to-back and mid-request reset.
module tb_denormalize;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] length;
   logic [31:0] nx, ny, nz;
   logic        busy;
   logic        done;
   logic [31:0] x, y, z;

   int checks;
   int failures;
   int lat;
   int lat2;
   int dones;
   int gaps;

   denormalize #(
      .WIDTH(32),
      .FRAC_WIDTH(30)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .length(length),
      .nx(nx),
      .ny(ny),
      .nz(nz),
      .busy(busy),
      .done(done),
      .x(x),
      .y(y),
      .z(z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(
      input string       tag,
      input logic [31:0] obs,
      input logic [31:0] exp
   );
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Drives one request; returns #1 after the edge that samples start.
   task automatic launch(
      input logic [31:0] l,
      input logic [31:0] a,
      input logic [31:0] b,
      input logic [31:0] c
   );
      start  = 1'b1;
      length = l;
      nx     = a;
      ny     = b;
      nz     = c;
      @(posedge clk);
      #1;
      start  = 1'b0;
      length = 32'hDEADBEEF;
      nx     = 32'hA5A5A5A5;
      ny     = 32'h5A5A5A5A;
      nz     = 32'hFFFFFFFF;
   endtask

   // Edges from the start edge until done is seen; -1 on timeout.
   task automatic wait_done(output int l, output int g);
      l = -1;
      g = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            l = k;
            break;
         end
         if (!busy) g++;
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b0;
      start    = 1'b0;
      length   = '0;
      nx       = '0;
      ny       = '0;
      nz       = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_x", x, 32'h0);
      check("rst_y", y, 32'h0);
      check("rst_z", z, 32'h0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // 0.5 * (0.6, -0.8, 0); -0x33333333/2 is an exact half,
      // rounding toward +inf gives -0x19999999 = 0xE6666667
      launch(32'h20000000, 32'h26666666, 32'hCCCCCCCD, 32'h0);
      check("basic_busy", {31'b0, busy}, 32'd1);
      wait_done(lat, gaps);
      check("basic_lat", lat, 32'd33);
      check("basic_gap", gaps, 32'd0);
      check("basic_busy_fall", {31'b0, busy}, 32'd0);
      check("basic_x", x, 32'h13333333);
      check("basic_y", y, 32'hE6666667);
      check("basic_z", z, 32'h0);
      @(posedge clk);
      #1;
      check("basic_pulse", {31'b0, done}, 32'd0);
      check("basic_hold_x", x, 32'h13333333);

      // 2.0 * (1.0, -1.0, 0): saturate high, exact low bound
      launch(32'h80000000, 32'h40000000, 32'hC0000000, 32'h0);
      wait_done(lat, gaps);
      check("sat_lat", lat, 32'd33);
      check("sat_x", x, 32'h7FFFFFFF);
      check("sat_y", y, 32'h80000000);
      check("sat_z", z, 32'h0);

      // zero length still takes the full latency
      launch(32'h0, 32'h40000000, 32'h40000000, 32'h40000000);
      wait_done(lat, gaps);
      check("zero_lat", lat, 32'd33);
      check("zero_x", x, 32'h0);
      check("zero_y", y, 32'h0);
      check("zero_z", z, 32'h0);

      // 0.25 * (1.0, -1.0, max); second start at cycle 10 ignored
      launch(32'h10000000, 32'h40000000, 32'hC0000000, 32'h7FFFFFFF);
      lat   = -1;
      dones = 0;
      gaps  = 0;
      for (int k = 1; k <= 45; k++) begin
         if (k == 10) begin
            start  = 1'b1;
            length = 32'h80000000;
            nx     = 32'h1;
            ny     = 32'h1;
            nz     = 32'h1;
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         if (done) begin
            dones++;
            if (lat < 0) lat = k;
         end else if (lat < 0 && !busy) begin
            gaps++;
         end
      end
      check("sbusy_dones", dones, 32'd1);
      check("sbusy_lat", lat, 32'd33);
      check("sbusy_gap", gaps, 32'd0);
      check("sbusy_x", x, 32'h10000000);
      check("sbusy_y", y, 32'hF0000000);
      check("sbusy_z", z, 32'h20000000);

      // 1.5 * (3, -3, 0.5) ulps: halves round up -> 5, -4
      launch(32'h60000000, 32'h00000003, 32'hFFFFFFFD, 32'h20000000);
      wait_done(lat, gaps);
      check("b2b_a_lat", lat, 32'd33);
      check("b2b_a_x", x, 32'h00000005);
      check("b2b_a_y", y, 32'hFFFFFFFC);
      check("b2b_a_z", z, 32'h30000000);
      // second start during the done cycle; 1.0 * n is identity
      launch(32'h40000000, 32'h12345678, 32'hFFFFFFFF, 32'h3FFFFFFF);
      check("b2b_accept", {31'b0, busy}, 32'd1);
      wait_done(lat2, gaps);
      check("b2b_spacing", lat2 + 1, 32'd34);
      check("b2b_b_x", x, 32'h12345678);
      check("b2b_b_y", y, 32'hFFFFFFFF);
      check("b2b_b_z", z, 32'h3FFFFFFF);

      // reset at cycle 15 of a request aborts it
      launch(32'h20000000, 32'h26666666, 32'hCCCCCCCD, 32'h0);
      repeat (14) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("mrst_busy", {31'b0, busy}, 32'd0);
      check("mrst_done", {31'b0, done}, 32'd0);
      check("mrst_x", x, 32'h0);
      check("mrst_y", y, 32'h0);
      check("mrst_z", z, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst   = 1'b1;
      dones = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (done) dones++;
      end
      check("mrst_no_done", dones, 32'd0);
      launch(32'h40000000, 32'h00000005, 32'h80000000, 32'h40000000);
      wait_done(lat, gaps);
      check("mrst_new_lat", lat, 32'd33);
      check("mrst_new_x", x, 32'h00000005);
      check("mrst_new_y", y, 32'h80000000);
      check("mrst_new_z", z, 32'h40000000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
